// File: rtl/ramp_adc_multi.sv
// Multi-channel single-slope ADC sequencer: discharges the external ramp, clocks it,
// times each synchronised comparator trip and drains per-channel results over valid/ready.
module ramp_adc_multi #(
  parameter int N_CH          = 2,
  parameter int CNT_W         = 10,
  parameter int CLK_DIV       = 2,
  parameter int DISCHARGE_CYC = 16,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             hf_osc,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic [N_CH-1:0]  comp_in,
  output logic             ramp_clk,
  output logic             ramp_rst,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic [CNT_W-1:0] res_data,
  output logic             res_ovf
);
  localparam int DW = $clog2(DISCHARGE_CYC + 1);
  localparam int VW = $clog2(CLK_DIV + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, DISCH, RAMP, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic [N_CH-1:0]              sync1_q, sync2_q;
  logic [DW-1:0]                disch_q, disch_d;
  logic [VW-1:0]                div_q, div_d;
  logic                         rclk_q, rclk_d;
  logic [CNT_W-1:0]             step_q, step_d;
  logic [N_CH-1:0]              cap_q, cap_d;
  logic [N_CH-1:0]              ovf_q, ovf_d;
  logic [N_CH-1:0][CNT_W-1:0]   slot_q, slot_d;
  logic [CH_W-1:0]              ptr_q, ptr_d;
  logic                         step_due;

  always_ff @(posedge hf_osc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      disch_q <= '0;
      div_q   <= '0;
      rclk_q  <= 1'b0;
      step_q  <= '0;
      cap_q   <= '0;
      ovf_q   <= '0;
      slot_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= comp_in;
      sync2_q <= sync1_q;
      disch_q <= disch_d;
      div_q   <= div_d;
      rclk_q  <= rclk_d;
      step_q  <= step_d;
      cap_q   <= cap_d;
      ovf_q   <= ovf_d;
      slot_q  <= slot_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    disch_d  = '0;
    div_d    = div_q;
    rclk_d   = 1'b0;
    step_d   = step_q;
    cap_d    = cap_q;
    ovf_d    = ovf_q;
    slot_d   = slot_q;
    ptr_d    = ptr_q;
    step_due = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = DISCH;
      end
      DISCH: begin
        disch_d = disch_q + 1'b1;
        div_d   = '0;
        step_d  = '0;
        cap_d   = '0;
        ovf_d   = '0;
        ptr_d   = '0;
        if (disch_q == DW'(DISCHARGE_CYC - 1)) state_d = RAMP;
      end
      RAMP: begin
        rclk_d = rclk_q;
        if (div_q == VW'(CLK_DIV - 1)) begin
          div_d    = '0;
          rclk_d   = ~rclk_q;
          step_due = ~rclk_q;
        end else begin
          div_d = div_q + 1'b1;
        end
        // Level capture uses the pre-increment count; one capture per channel per ramp.
        for (int i = 0; i < N_CH; i++) begin
          if (!cap_q[i] && sync2_q[i]) begin
            cap_d[i]  = 1'b1;
            slot_d[i] = step_q;
          end
        end
        if (&cap_d) begin
          state_d = DRAIN;
          rclk_d  = 1'b0;
        end else if (step_due && (&step_q)) begin
          // Counter would wrap: flag every channel that never tripped.
          state_d = DRAIN;
          rclk_d  = 1'b0;
          for (int i = 0; i < N_CH; i++) begin
            if (!cap_d[i]) begin
              slot_d[i] = '1;
              ovf_d[i]  = 1'b1;
            end
          end
        end else if (step_due) begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (ptr_q == LAST_CH) begin
            ptr_d   = '0;
            state_d = continuous ? DISCH : IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ramp_clk  = rclk_q;
  assign ramp_rst  = (state_q != RAMP);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DRAIN);
  assign res_ch    = ptr_q;
  assign res_data  = slot_q[ptr_q];
  assign res_ovf   = ovf_q[ptr_q];
endmodule
